// File: rtl/text_line_reader_pkg.sv
// Shared types and constants for the text RAM line reader.
// TEXT_BLANK_CHAR is also used by the write side when it erases text.
package text_line_reader_pkg;

  localparam int CONSOLE_COLUMNS        = 80;
  localparam int CONSOLE_LINES          = 50;
  localparam int TEXT_RAM_CHAR_WIDTH    = 32;
  localparam int TEXT_RAM_READ_LATENCY  = 2;
  localparam int TEXT_RAM_LINE_WIDTH    = CONSOLE_COLUMNS * TEXT_RAM_CHAR_WIDTH;

  typedef struct packed {
    logic [23:0] attr;
    logic [7:0]  code;
  } text_ram_char_t;

  localparam text_ram_char_t TEXT_BLANK_CHAR = 32'h0007fc20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_BLANK
  } reader_state_t;

endpackage

// File: rtl/text_line_reader_buffer.sv
// Ping-pong pair of line buffers: whole-line load into bank sel,
// registered per-column lookup from the other bank.
module text_line_reader_buffer
  import text_line_reader_pkg::*;
#(
  parameter int COLUMNS    = CONSOLE_COLUMNS,
  parameter int CHAR_WIDTH = TEXT_RAM_CHAR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          sel,
  input  logic [COLUMNS*CHAR_WIDTH-1:0] wr_line,
  input  logic                          rd_en,
  input  logic [7:0]                    rd_col,
  input  logic                          rd_blank,
  output logic [7:0]                    char_code,
  output logic [CHAR_WIDTH-9:0]         char_attr,
  output logic                          char_valid
);

  localparam int                    IDX_W      = $clog2(COLUMNS);
  localparam logic [7:0]            COL_LIMIT  = 8'(COLUMNS);
  localparam logic [CHAR_WIDTH-1:0] BLANK_CHAR = CHAR_WIDTH'(TEXT_BLANK_CHAR);

  logic [CHAR_WIDTH-1:0] bank [2][COLUMNS];
  logic [CHAR_WIDTH-1:0] rd_word;

  // Line storage carries no reset; validity is tracked by the reader.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < COLUMNS; i++) begin
        bank[sel][i] <= wr_line[CHAR_WIDTH*i +: CHAR_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = BLANK_CHAR;
    if (!rd_blank && (rd_col < COL_LIMIT)) begin
      rd_word = bank[~sel][rd_col[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_valid <= 1'b0;
      char_code  <= BLANK_CHAR[7:0];
      char_attr  <= BLANK_CHAR[CHAR_WIDTH-1:8];
    end else begin
      char_valid <= rd_en;
      if (rd_en) begin
        char_code <= rd_word[7:0];
        char_attr <= rd_word[CHAR_WIDTH-1:8];
      end
    end
  end

endmodule

// File: rtl/text_line_reader.sv
// Fetches one text line from the RAM read port into the back line buffer
// and serves column lookups from the front buffer.
//
// state   | meaning
// IDLE    | waiting for fetch_req
// ISSUE   | ram_rden high for one cycle with the row address
// WAIT    | counting down the RAM read latency
// CAPTURE | ram_q valid, written into the back buffer
// BLANK   | row out of range, back buffer filled with blanks
module text_line_reader
  import text_line_reader_pkg::*;
#(
  parameter int COLUMNS      = CONSOLE_COLUMNS,
  parameter int LINES        = CONSOLE_LINES,
  parameter int CHAR_WIDTH   = TEXT_RAM_CHAR_WIDTH,
  parameter int READ_LATENCY = TEXT_RAM_READ_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_req,
  input  logic [7:0]                    fetch_row,
  output logic                          fetch_busy,
  output logic                          fetch_done,
  input  logic                          swap,
  output logic [7:0]                    ram_address,
  output logic                          ram_rden,
  input  logic [COLUMNS*CHAR_WIDTH-1:0] ram_q,
  input  logic [7:0]                    col,
  input  logic                          col_valid,
  output logic [7:0]                    char_code,
  output logic [CHAR_WIDTH-9:0]         char_attr,
  output logic                          char_valid
);

  localparam logic [CHAR_WIDTH-1:0] BLANK_CHAR  = CHAR_WIDTH'(TEXT_BLANK_CHAR);
  localparam logic [7:0]            LINES_LIMIT = 8'(LINES);
  localparam logic [7:0]            WAIT_INIT   = 8'(READ_LATENCY - 1);

  reader_state_t                 state;
  logic [7:0]                    wait_cnt;
  logic                          front_sel;
  logic                          front_valid;
  logic                          back_valid;
  logic                          line_write;
  logic [COLUMNS*CHAR_WIDTH-1:0] line_data;

  assign line_write = (state == ST_CAPTURE) || (state == ST_BLANK);
  assign line_data  = (state == ST_BLANK) ? {COLUMNS{BLANK_CHAR}} : ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      fetch_busy  <= 1'b0;
      fetch_done  <= 1'b0;
      ram_rden    <= 1'b0;
      ram_address <= '0;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      back_valid  <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_req) begin
            fetch_busy <= 1'b1;
            if (fetch_row < LINES_LIMIT) begin
              state       <= ST_ISSUE;
              ram_address <= fetch_row;
              ram_rden    <= 1'b1;
            end else begin
              state <= ST_BLANK;
            end
          end
        end
        ST_ISSUE: begin
          ram_rden <= 1'b0;
          if (READ_LATENCY <= 1) begin
            state <= ST_CAPTURE;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt == 8'd1) state <= ST_CAPTURE;
        end
        ST_CAPTURE, ST_BLANK: begin
          state      <= ST_IDLE;
          fetch_busy <= 1'b0;
          fetch_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      // A swap coinciding with a line write promotes that freshly written line.
      if (swap) begin
        front_sel   <= ~front_sel;
        front_valid <= back_valid | line_write;
        back_valid  <= 1'b0;
      end else if (line_write) begin
        back_valid <= 1'b1;
      end
    end
  end

  text_line_reader_buffer #(
    .COLUMNS   (COLUMNS),
    .CHAR_WIDTH(CHAR_WIDTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (line_write),
    .sel       (~front_sel),
    .wr_line   (line_data),
    .rd_en     (col_valid),
    .rd_col    (col),
    .rd_blank  (~front_valid),
    .char_code (char_code),
    .char_attr (char_attr),
    .char_valid(char_valid)
  );

endmodule

// File: tb/tb_text_line_reader.sv
// Directed bench for text_line_reader with a latency-2 text RAM model.
module tb_text_line_reader;
  import text_line_reader_pkg::*;

  localparam int COLS = 80;
  localparam int CW   = 32;

  typedef struct {
    logic        do_fetch;
    logic [7:0]  row;
    logic        do_swap;
    logic [7:0]  col;
    logic        colv;
    logic        exp_v;
    logic [7:0]  exp_code;
    logic [23:0] exp_attr;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fetch_req = 1'b0;
  logic [7:0]       fetch_row = 8'd0;
  logic             swap = 1'b0;
  logic [7:0]       col = 8'd0;
  logic             col_valid = 1'b0;
  logic             fetch_busy, fetch_done, ram_rden, char_valid;
  logic [7:0]       ram_address, char_code;
  logic [23:0]      char_attr;
  logic [COLS*CW-1:0] ram_q;

  int n_vec = 0;
  int n_bad = 0;
  int rden_seen = 0;
  int done_seen = 0;
  int r0, d0;

  logic [31:0] mem [50][80];
  logic        p_v = 1'b0;
  logic [7:0]  p_a = 8'd0;
  vec_t        tbl [13];

  always #5 clk = ~clk;

  text_line_reader dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_row  (fetch_row),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .swap       (swap),
    .ram_address(ram_address),
    .ram_rden   (ram_rden),
    .ram_q      (ram_q),
    .col        (col),
    .col_valid  (col_valid),
    .char_code  (char_code),
    .char_attr  (char_attr),
    .char_valid (char_valid)
  );

  // RAM: address sampled with rden, data valid two cycles later, junk otherwise.
  always @(posedge clk) begin
    if (ram_rden) rden_seen++;
    if (fetch_done) done_seen++;
    p_v <= ram_rden;
    p_a <= ram_address;
    for (int c = 0; c < COLS; c++)
      ram_q[c*CW +: CW] <= (p_v && p_a < 8'd50) ? mem[p_a[5:0]][c] : 32'hDEADBEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input logic [7:0] row);
    logic seen;
    seen = 1'b0;
    fetch_req = 1'b1;
    fetch_row = row;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (fetch_done) seen = 1'b1;
      else tick();
    end
    check("fetch_done_seen", 32'(seen), 32'd1);
    tick();
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [7:0] c, input logic v,
                        input logic ev, input logic [7:0] ec, input logic [23:0] ea);
    col = c;
    col_valid = v;
    tick();
    col_valid = 1'b0;
    check({tag, "_valid"}, 32'(char_valid), 32'(ev));
    check({tag, "_code"}, 32'(char_code), 32'(ec));
    check({tag, "_attr"}, 32'(char_attr), 32'(ea));
  endtask

  function automatic vec_t mk(logic f, logic [7:0] row, logic s, logic [7:0] c, logic v,
                              logic ev, logic [7:0] ec, logic [23:0] ea);
    vec_t t;
    t.do_fetch = f; t.row = row; t.do_swap = s; t.col = c; t.colv = v;
    t.exp_v = ev; t.exp_code = ec; t.exp_attr = ea;
    return t;
  endfunction

  initial begin
    for (int r = 0; r < 50; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = {8'h10, 8'(r), 8'(c), 8'(8'h61 + r)};
    mem[5][3] = 32'h0007fc41;

    //            fetch row    swap  col    colv  ev    code   attr
    tbl[0]  = mk(0, 8'd0,  0, 8'd3,   1, 1, 8'h20, 24'h0007fc); // front not yet valid
    tbl[1]  = mk(0, 8'd0,  1, 8'd3,   1, 1, 8'h41, 24'h0007fc);
    tbl[2]  = mk(0, 8'd0,  0, 8'd0,   1, 1, 8'h66, 24'h100500);
    tbl[3]  = mk(0, 8'd0,  0, 8'd79,  1, 1, 8'h66, 24'h10054f);
    tbl[4]  = mk(0, 8'd0,  0, 8'd0,   0, 0, 8'h66, 24'h10054f); // hold
    tbl[5]  = mk(0, 8'd0,  0, 8'd80,  1, 1, 8'h20, 24'h0007fc);
    tbl[6]  = mk(0, 8'd0,  0, 8'd200, 1, 1, 8'h20, 24'h0007fc);
    tbl[7]  = mk(1, 8'd60, 1, 8'd0,   1, 1, 8'h20, 24'h0007fc);
    tbl[8]  = mk(0, 8'd0,  0, 8'd79,  1, 1, 8'h20, 24'h0007fc);
    tbl[9]  = mk(1, 8'd49, 1, 8'd10,  1, 1, 8'h92, 24'h10310a);
    tbl[10] = mk(1, 8'd50, 1, 8'd10,  1, 1, 8'h20, 24'h0007fc);
    tbl[11] = mk(1, 8'd0,  1, 8'd1,   1, 1, 8'h61, 24'h100001);
    tbl[12] = mk(0, 8'd0,  1, 8'd1,   1, 1, 8'h20, 24'h0007fc); // back was empty

    // Reset values
    tick();
    tick();
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_done", 32'(fetch_done), 32'd0);
    check("rst_rden", 32'(ram_rden), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_cvalid", 32'(char_valid), 32'd0);
    check("rst_code", 32'(char_code), 32'h20);
    check("rst_attr", 32'(char_attr), 32'h0007fc);
    rst = 1'b0;
    tick();

    // Line fetch timing, row 5
    fetch_req = 1'b1;
    fetch_row = 8'd5;
    check("a_c0_busy", 32'(fetch_busy), 32'd0);
    tick();
    fetch_req = 1'b0;
    check("a_c1_rden", 32'(ram_rden), 32'd1);
    check("a_c1_addr", 32'(ram_address), 32'd5);
    check("a_c1_busy", 32'(fetch_busy), 32'd1);
    check("a_c1_done", 32'(fetch_done), 32'd0);
    tick();
    check("a_c2_rden", 32'(ram_rden), 32'd0);
    check("a_c2_busy", 32'(fetch_busy), 32'd1);
    tick();
    check("a_c3_busy", 32'(fetch_busy), 32'd1);
    check("a_c3_done", 32'(fetch_done), 32'd0);
    tick();
    check("a_c4_done", 32'(fetch_done), 32'd1);
    check("a_c4_busy", 32'(fetch_busy), 32'd0);
    tick();
    check("a_c5_done", 32'(fetch_done), 32'd0);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].do_fetch) do_fetch(tbl[i].row);
      if (tbl[i].do_swap) pulse_swap();
      lookup($sformatf("vec%0d", i), tbl[i].col, tbl[i].colv,
             tbl[i].exp_v, tbl[i].exp_code, tbl[i].exp_attr);
    end

    // Blank fetch timing
    r0 = rden_seen;
    d0 = done_seen;
    fetch_req = 1'b1;
    fetch_row = 8'd60;
    tick();
    fetch_req = 1'b0;
    check("b_c1_busy", 32'(fetch_busy), 32'd1);
    check("b_c1_rden", 32'(ram_rden), 32'd0);
    check("b_c1_done", 32'(fetch_done), 32'd0);
    tick();
    check("b_c2_done", 32'(fetch_done), 32'd1);
    check("b_c2_busy", 32'(fetch_busy), 32'd0);
    tick();
    check("b_rden_count", 32'(rden_seen - r0), 32'd0);
    check("b_done_count", 32'(done_seen - d0), 32'd1);

    // Ping-pong with continuous lookups at col 2
    do_fetch(8'd1);
    pulse_swap();
    begin
      logic seen;
      seen = 1'b0;
      col = 8'd2;
      col_valid = 1'b1;
      fetch_req = 1'b1;
      fetch_row = 8'd2;
      tick();
      fetch_req = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
        check("pp_before", {23'd0, char_valid, char_code}, 32'h162);
        if (fetch_done) seen = 1'b1;
        else tick();
      end
      check("pp_done_seen", 32'(seen), 32'd1);
      swap = 1'b1;
      tick();
      swap = 1'b0;
      check("pp_swap_cycle", {23'd0, char_valid, char_code}, 32'h162);
      tick();
      check("pp_after_code", {23'd0, char_valid, char_code}, 32'h163);
      check("pp_after_attr", 32'(char_attr), 32'h100202);
      col_valid = 1'b0;
      tick();
    end

    // Swap in the CAPTURE cycle
    fetch_req = 1'b1;
    fetch_row = 8'd3;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check("d_done", 32'(fetch_done), 32'd1);
    lookup("d_front", 8'd4, 1'b1, 1'b1, 8'h64, 24'h100304);
    pulse_swap();
    lookup("d_empty", 8'd4, 1'b1, 1'b1, 8'h20, 24'h0007fc);

    // Request while busy is dropped
    r0 = rden_seen;
    d0 = done_seen;
    fetch_req = 1'b1;
    fetch_row = 8'd8;
    tick();
    fetch_row = 8'd7;
    tick();
    fetch_req = 1'b0;
    check("e_addr", 32'(ram_address), 32'd8);
    repeat (6) tick();
    check("e_rden_count", 32'(rden_seen - r0), 32'd1);
    check("e_done_count", 32'(done_seen - d0), 32'd1);
    pulse_swap();
    lookup("e_row8", 8'd0, 1'b1, 1'b1, 8'h69, 24'h100800);

    // Reset in cycle 2 of a fetch
    d0 = done_seen;
    fetch_req = 1'b1;
    fetch_row = 8'd9;
    tick();
    fetch_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("f_busy", 32'(fetch_busy), 32'd0);
    check("f_rden", 32'(ram_rden), 32'd0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("f_no_done", 32'(done_seen - d0), 32'd0);
    lookup("f_after_rst", 8'd0, 1'b1, 1'b1, 8'h20, 24'h0007fc);
    do_fetch(8'd9);
    lookup("f_no_swap", 8'd0, 1'b1, 1'b1, 8'h20, 24'h0007fc);
    pulse_swap();
    lookup("f_row9", 8'd0, 1'b1, 1'b1, 8'h6a, 24'h100900);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/text_line_reader.md
Name: text_line_reader

Overview:
- Read-side client of the text RAM, on the second port.
- Takes a row index from the display renderer and fetches that whole line with a fixed-latency read.
- Stores the line in a ping-pong pair of line buffers.
- Serves per-column character/attribute lookups to the glyph renderer from the front buffer while the next line prefetches into the back buffer.

Parameters:
- COLUMNS, 80, characters per line (`CONSOLE_COLUMNS).
- LINES, 50, valid rows (`CONSOLE_LINES).
- CHAR_WIDTH, 32, bits per stored character (`TEXT_RAM_CHAR_WIDTH); [7:0] is the code, [CHAR_WIDTH-1:8] is the attribute.
- READ_LATENCY, 2, cycles from address/rden sampled by the RAM until ram_q is valid.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  one-cycle pulse: fetch row fetch_row into the back buffer
- fetch_row  in  8  row index; sampled with fetch_req
- fetch_busy  out  1  fetch in progress
- fetch_done  out  1  one-cycle pulse: back buffer now holds the requested line
- swap  in  1  one-cycle pulse: exchange front and back buffers
- ram_address  out  8  text RAM read address
- ram_rden  out  1  text RAM read enable
- ram_q  in  COLUMNS*CHAR_WIDTH  text RAM read data; char i sits at [CHAR_WIDTH*i +: CHAR_WIDTH]
- col  in  8  column lookup index
- col_valid  in  1  lookup strobe
- char_code  out  8  looked-up character code
- char_attr  out  CHAR_WIDTH-8  looked-up attribute
- char_valid  out  1  lookup result valid

Behaviour:
- Reset values: fetch_busy=0, fetch_done=0, ram_rden=0, ram_address=0, char_valid=0, char_code=8'h20, char_attr=BLANK_CHAR[CHAR_WIDTH-1:8], front_sel=0, front_valid=0, back_valid=0.
- Buffer contents are not reset.
- All outputs are registered.
- FSM states:
  - IDLE: on fetch_req with fetch_row<LINES, go to ISSUE; on fetch_req with fetch_row>=LINES, go to BLANK.
  - ISSUE: one cycle; ram_address=row, ram_rden=1. Then go to WAIT with counter=READ_LATENCY-1.
  - WAIT: ram_rden=0; decrement the counter. At 0, go to CAPTURE.
  - CAPTURE: write ram_q into the back buffer, set back_valid, pulse fetch_done next cycle, return to IDLE.
  - BLANK: fill the back buffer with BLANK_CHAR (32'h0007fc20), no RAM access, set back_valid, pulse fetch_done next cycle, return to IDLE.
- fetch_busy=1 whenever state != IDLE.
- Timing for fetch_req in cycle 0 with READ_LATENCY=2:
  - rden high in cycle 1 only.
  - ram_q captured at the end of cycle 3.
  - fetch_done high in cycle 4.
  - fetch_busy high in cycles 1-3.
- Blank fetch: fetch_done in cycle 2; fetch_busy high in cycle 1 only.
- fetch_req while busy is ignored; no queueing. fetch_done pulses once per accepted request.
- Swap: toggles front_sel, front_valid<=back_valid, back_valid<=0.
- Swap and CAPTURE in the same cycle: the capture targets the pre-swap back buffer. That line becomes the front with front_valid=1, and back_valid ends at 0.
- Swap during ISSUE/WAIT: the pending capture lands in the new back buffer (the old front), which is correct because that buffer is no longer displayed.
- Lookup latency is 1: col_valid in cycle n gives char_valid=1 with code/attr in cycle n+1, read from the front buffer as selected at cycle n.
  - If front_valid=0 or col>=COLUMNS, the result is 8'h20 with the BLANK_CHAR attribute.
  - char_valid=0 in any cycle following col_valid=0; code/attr hold their values.
- A lookup in the same cycle as swap uses the pre-swap front.
- Reset asserted mid-fetch: return to IDLE immediately, drop rden, no fetch_done. RAM data returning after reset is ignored.

Decomposition:
- Shared package (DataType.svh), new items:
  - TextRamChar_t packed struct: attr + code.
  - TEXT_BLANK_CHAR constant = 32'h0007fc20 (also used by the write side's erase path).
- Existing items already there: `TEXT_RAM_LINE_WIDTH, `CONSOLE_COLUMNS, `CONSOLE_LINES.
- Sub-module text_line_buffer:
  - Holds the two line banks.
  - Write: whole-line load into bank sel.
  - Read: registered per-column mux on bank ~sel.
- text_line_reader holds the FSM, valid flags and the RAM handshake.

Test Plan:
- Line fetch: RAM model (latency 2) preloads row 5 col 3 = 32'h0007fc41. fetch_req row=5 in cycle 0, swap after fetch_done, lookup col=3 -> rden only in cycle 1 with address 5; fetch_done in cycle 4; char_code=8'h41, char_attr=24'h0007fc one cycle after col_valid.
- Out-of-range: fetch_req row=60, swap, lookup col=0 and col=79 -> no rden; fetch_done cycle 2; both return 8'h20 / 24'h0007fc.
- Ping-pong: fetch row 1, swap, fetch row 2 while looking up continuously -> lookups return row-1 data until the second swap, row-2 data from the lookup issued the cycle after that swap.
- Simultaneous swap+CAPTURE -> captured row is front immediately (front_valid=1); a second swap with no fetch gives blank output (back_valid was 0).
- Ignored request and reset: fetch_req row=7 while busy -> only one rden (original row) and one fetch_done. rst asserted in cycle 2 of a fetch -> fetch_busy=0, no fetch_done, lookups return 8'h20 until a new fetch+swap.
- col=80 with valid front -> 8'h20 with blank attribute, char_valid=1.
